// File: rtl/rx_block_packer.sv
`default_nettype none
// ============================================================================
// Module   : rx_block_packer
// Brief    : Packs received UART bytes into one 128-bit AES block and presents
//            it on an AXI-Stream master. Partial blocks are discarded on
//            inter-byte timeout or flush, and each discard is counted.
// Revision : 1.0 - initial release
// ============================================================================
module rx_block_packer #(
  parameter int BYTES  = 16,
  parameter int TO_W   = 16,
  parameter int DROP_W = 8
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 En,
  input  logic                 Flush,
  input  logic [TO_W-1:0]      TimeoutCycles,
  input  logic [7:0]           s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic [BYTES*8-1:0]   m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic [4:0]           ByteCount,
  output logic                 TimeoutErr,
  output logic [DROP_W-1:0]    DropCount
);

  localparam int         c_DATA_W = BYTES * 8;
  localparam logic [4:0] c_LAST   = 5'(BYTES - 1);
  localparam logic [4:0] c_FULL   = 5'(BYTES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [c_DATA_W-1:0] r_buf, w_buf_nxt, w_buf_ins;
  logic [c_DATA_W-1:0] r_tdata, w_tdata_nxt;
  logic                r_tvalid, w_tvalid_nxt;
  logic [4:0]          r_count, w_count_nxt;
  logic [TO_W-1:0]     r_to_cnt, w_to_cnt_nxt;
  logic                r_terr, w_terr_nxt;
  logic [DROP_W-1:0]   r_drop;
  logic                w_drop;
  logic                w_xfer;
  logic                w_out_hs;
  logic                w_to_active;
  logic                w_to_expire;

  // Input side accepts only while collecting; reset also masks it so the
  // port reads 0 while Rst is held.
  assign s_axis_tready = En && !Flush && !Rst &&
                         ((r_state == S_IDLE) || (r_state == S_FILL));

  assign w_xfer   = s_axis_tvalid && s_axis_tready;
  assign w_out_hs = r_tvalid && m_axis_tready;

  // The timeout threshold is compared live so a new TimeoutCycles value
  // applies on the very next cycle.
  assign w_to_active = En && (TimeoutCycles != '0) && (r_state == S_FILL);
  assign w_to_expire = w_to_active && !w_xfer &&
                       (r_to_cnt == (TimeoutCycles - TO_W'(1)));

  // Next-state and datapath decode; defaults hold every register.
  always_comb begin
    w_state_nxt  = r_state;
    w_buf_nxt    = r_buf;
    w_tdata_nxt  = r_tdata;
    w_tvalid_nxt = r_tvalid;
    w_count_nxt  = r_count;
    w_to_cnt_nxt = r_to_cnt;
    w_terr_nxt   = 1'b0;
    w_drop       = 1'b0;

    // Byte k of the block lands in the k-th byte from the MSB end.
    w_buf_ins = r_buf;
    for (int k = 0; k < BYTES; k++) begin
      if (r_count == 5'(k)) begin
        w_buf_ins[c_DATA_W-1-8*k -: 8] = s_axis_tdata;
      end
    end

    case (r_state)
      S_IDLE: begin
        if (w_xfer) begin
          w_buf_nxt    = w_buf_ins;
          w_count_nxt  = 5'd1;
          w_to_cnt_nxt = '0;
          w_state_nxt  = S_FILL;
        end
      end

      S_FILL: begin
        if (Flush) begin
          // Flush wins over a coincident timeout; counted once, no error pulse.
          w_count_nxt  = '0;
          w_to_cnt_nxt = '0;
          w_drop       = 1'b1;
          w_state_nxt  = S_IDLE;
        end else if (w_xfer) begin
          w_buf_nxt    = w_buf_ins;
          w_to_cnt_nxt = '0;
          if (r_count == c_LAST) begin
            w_tdata_nxt  = w_buf_ins;
            w_tvalid_nxt = 1'b1;
            w_count_nxt  = c_FULL;
            w_state_nxt  = S_OUT;
          end else begin
            w_count_nxt = r_count + 5'd1;
          end
        end else if (w_to_expire) begin
          w_count_nxt  = '0;
          w_to_cnt_nxt = '0;
          w_terr_nxt   = 1'b1;
          w_drop       = 1'b1;
          w_state_nxt  = S_IDLE;
        end else if (w_to_active) begin
          w_to_cnt_nxt = r_to_cnt + TO_W'(1);
        end
      end

      S_OUT: begin
        // A completed handshake beats a coincident flush: the block is delivered.
        if (w_out_hs) begin
          w_tvalid_nxt = 1'b0;
          w_count_nxt  = '0;
          w_state_nxt  = S_IDLE;
        end else if (Flush) begin
          w_tvalid_nxt = 1'b0;
          w_count_nxt  = '0;
          w_drop       = 1'b1;
          w_state_nxt  = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath registers: byte buffer, output block, counters and status.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_buf    <= '0;
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
      r_count  <= '0;
      r_to_cnt <= '0;
      r_terr   <= 1'b0;
    end else begin
      r_buf    <= w_buf_nxt;
      r_tdata  <= w_tdata_nxt;
      r_tvalid <= w_tvalid_nxt;
      r_count  <= w_count_nxt;
      r_to_cnt <= w_to_cnt_nxt;
      r_terr   <= w_terr_nxt;
    end
  end

  // Saturating discard counter; sticks at all-ones.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_drop <= '0;
    end else if (w_drop && (r_drop != {DROP_W{1'b1}})) begin
      r_drop <= r_drop + DROP_W'(1);
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign ByteCount     = r_count;
  assign TimeoutErr    = r_terr;
  assign DropCount     = r_drop;

endmodule
`default_nettype wire
